// File: rtl/fc_pkg.sv
// Shared types and helpers for the time-multiplexed fully connected stack.
package fc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MAC,
    ST_ACT
  } state_t;

  typedef enum logic [1:0] {
    LY_HID,
    LY_DNS,
    LY_OUT
  } layer_t;

  // Weight memory layout: all hidden neurons, then dense, then the output neuron.
  function automatic int unsigned hid_base();
    return 0;
  endfunction

  function automatic int unsigned dns_base(input int unsigned n, input int unsigned h);
    return n * h;
  endfunction

  function automatic int unsigned out_base(input int unsigned n, input int unsigned h,
                                           input int unsigned d);
    return n * h + d * h;
  endfunction

  // Arithmetic right shift then clamp to a signed w-bit range; caller keeps the low w bits.
  function automatic logic signed [63:0] sat_shift(input logic signed [63:0] acc,
                                                   input int unsigned frac,
                                                   input int unsigned w);
    logic signed [63:0] sh;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sh = acc >>> frac;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (sh > hi) return hi;
    if (sh < lo) return lo;
    return sh;
  endfunction

endpackage

// File: rtl/fc_mac_unit.sv
// Shared signed multiply-accumulate with clear/enable and a shifted, saturated view of the sum.
module fc_mac_unit
  import fc_pkg::*;
#(
  parameter int IP_DATA_WIDTH = 8,
  parameter int ACC_WIDTH     = 24,
  parameter int FRAC_BITS     = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clr,
  input  logic                            en,
  input  logic signed [IP_DATA_WIDTH-1:0] a,
  input  logic signed [IP_DATA_WIDTH-1:0] b,
  output logic signed [IP_DATA_WIDTH-1:0] sat_out
);

  localparam int W = IP_DATA_WIDTH;

  logic signed [2*W-1:0]       prod;
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [63:0]          acc_ext;
  logic signed [63:0]          sat_full;

  assign prod = (2*W)'(a) * (2*W)'(b);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + ACC_WIDTH'(prod);
    end
  end

  assign acc_ext  = 64'(acc);
  assign sat_full = sat_shift(acc_ext, FRAC_BITS, W);
  assign sat_out  = sat_full[W-1:0];

endmodule

// File: rtl/fc_layer_sequencer.sv
// Sequences hidden, dense and output neurons through one shared MAC using external weight/feature memories.
module fc_layer_sequencer
  import fc_pkg::*;
#(
  parameter int IP_DATA_WIDTH       = 8,
  parameter int NUM_IP              = 8,
  parameter int IP_LAYER_NEURONS    = 3,
  parameter int DENSE_LAYER_NEURONS = 2,
  parameter int FRAC_BITS           = 4,
  parameter int ACC_WIDTH           = 24,
  parameter int ADDR_WIDTH          = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  output logic                            busy,
  output logic                            done,
  output logic [ADDR_WIDTH-1:0]           x_addr,
  input  logic signed [IP_DATA_WIDTH-1:0] x_rdata,
  output logic [ADDR_WIDTH-1:0]           wt_addr,
  input  logic signed [IP_DATA_WIDTH-1:0] wt_rdata,
  output logic signed [IP_DATA_WIDTH-1:0] act_in,
  input  logic signed [IP_DATA_WIDTH-1:0] act_out,
  output logic signed [IP_DATA_WIDTH-1:0] out,
  output logic                            out_valid
);

  localparam int W    = IP_DATA_WIDTH;
  localparam int H    = IP_LAYER_NEURONS;
  localparam int D    = DENSE_LAYER_NEURONS;
  localparam int KMAX = (NUM_IP > H) ? ((NUM_IP > D) ? NUM_IP : D) : ((H > D) ? H : D);
  localparam int CW   = $clog2(KMAX + 1) + 1;

  localparam logic [CW-1:0] K_HID = CW'(NUM_IP);
  localparam logic [CW-1:0] K_DNS = CW'(H);
  localparam logic [CW-1:0] K_OUT = CW'(D);

  state_t              state;
  layer_t              layer;
  layer_t              next_layer;
  logic [CW-1:0]       neuron;
  logic [CW-1:0]       cyc;
  logic [CW-1:0]       k_cur;
  logic [CW-1:0]       n_last;
  logic signed [W-1:0] hid_r [H];
  logic signed [W-1:0] dns_r [D];
  logic signed [W-1:0] op_reg;
  logic signed [W-1:0] rf_sel;
  logic signed [W-1:0] mac_a;
  logic                mac_clr;
  logic                mac_en;

  function automatic logic [ADDR_WIDTH-1:0] waddr(input layer_t l, input logic [CW-1:0] n,
                                                  input logic [CW-1:0] i);
    int unsigned a;
    a = 0;
    case (l)
      LY_HID:  a = hid_base() + 32'(n) * NUM_IP + 32'(i);
      LY_DNS:  a = dns_base(NUM_IP, H) + 32'(n) * H + 32'(i);
      LY_OUT:  a = out_base(NUM_IP, H, D) + 32'(i);
      default: a = 0;
    endcase
    return ADDR_WIDTH'(a);
  endfunction

  always_comb begin
    k_cur      = K_HID;
    n_last     = CW'(H - 1);
    next_layer = LY_DNS;
    case (layer)
      LY_HID:  begin k_cur = K_HID; n_last = CW'(H - 1); next_layer = LY_DNS; end
      LY_DNS:  begin k_cur = K_DNS; n_last = CW'(D - 1); next_layer = LY_OUT; end
      LY_OUT:  begin k_cur = K_OUT; n_last = '0;         next_layer = LY_OUT; end
      default: begin k_cur = K_HID; n_last = CW'(H - 1); next_layer = LY_DNS; end
    endcase
  end

  // Internal activations are read in the addressing cycle and registered so they meet wt_rdata.
  always_comb begin
    rf_sel = '0;
    if (layer == LY_DNS) begin
      for (int unsigned j = 0; j < H; j++)
        if (cyc == CW'(j)) rf_sel = hid_r[j];
    end else if (layer == LY_OUT) begin
      for (int unsigned j = 0; j < D; j++)
        if (cyc == CW'(j)) rf_sel = dns_r[j];
    end
  end

  assign mac_a   = (layer == LY_HID) ? x_rdata : op_reg;
  assign mac_en  = (state == ST_MAC) && (cyc != '0);
  assign mac_clr = (state == ST_IDLE) || (state == ST_ACT);

  fc_mac_unit #(
    .IP_DATA_WIDTH(IP_DATA_WIDTH),
    .ACC_WIDTH    (ACC_WIDTH),
    .FRAC_BITS    (FRAC_BITS)
  ) u_mac (
    .clk    (clk),
    .rst    (rst),
    .clr    (mac_clr),
    .en     (mac_en),
    .a      (mac_a),
    .b      (wt_rdata),
    .sat_out(act_in)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      layer     <= LY_HID;
      neuron    <= '0;
      cyc       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out       <= '0;
      out_valid <= 1'b0;
      x_addr    <= '0;
      wt_addr   <= '0;
      op_reg    <= '0;
      for (int unsigned j = 0; j < H; j++) hid_r[j] <= '0;
      for (int unsigned j = 0; j < D; j++) dns_r[j] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_MAC;
            layer     <= LY_HID;
            neuron    <= '0;
            cyc       <= '0;
            busy      <= 1'b1;
            out_valid <= 1'b0;
            x_addr    <= '0;
            wt_addr   <= waddr(LY_HID, '0, '0);
          end
        end
        ST_MAC: begin
          cyc <= cyc + CW'(1);
          if (cyc < k_cur) op_reg <= rf_sel;
          // Addresses are registered: the value set here is presented in the next cycle.
          if (cyc + CW'(1) < k_cur) begin
            wt_addr <= waddr(layer, neuron, cyc + CW'(1));
            x_addr  <= (layer == LY_HID) ? ADDR_WIDTH'(cyc + CW'(1)) : '0;
          end else begin
            wt_addr <= '0;
            x_addr  <= '0;
          end
          if (cyc == k_cur) state <= ST_ACT;
        end
        ST_ACT: begin
          for (int unsigned j = 0; j < H; j++)
            if (layer == LY_HID && neuron == CW'(j)) hid_r[j] <= act_out;
          for (int unsigned j = 0; j < D; j++)
            if (layer == LY_DNS && neuron == CW'(j)) dns_r[j] <= act_out;
          cyc <= '0;
          if (neuron != n_last) begin
            neuron  <= neuron + CW'(1);
            state   <= ST_MAC;
            wt_addr <= waddr(layer, neuron + CW'(1), '0);
          end else if (layer == LY_OUT) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b1;
            out       <= act_out;
            out_valid <= 1'b1;
          end else begin
            layer   <= next_layer;
            neuron  <= '0;
            state   <= ST_MAC;
            wt_addr <= waddr(next_layer, '0, '0);
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Directed bench for fc_layer_sequencer with behavioural weight/feature memories and identity or ReLU activation.
module tb_fc_layer_sequencer;

  localparam int W  = 8;
  localparam int AW = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic                 busy;
  logic                 done;
  logic [AW-1:0]        x_addr;
  logic [AW-1:0]        wt_addr;
  logic signed [W-1:0]  x_rdata;
  logic signed [W-1:0]  wt_rdata;
  logic signed [W-1:0]  act_in;
  logic signed [W-1:0]  act_out;
  logic signed [W-1:0]  out;
  logic                 out_valid;
  logic                 relu;

  logic signed [W-1:0]  x_mem [256];
  logic signed [W-1:0]  w_mem [256];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    x_rdata  <= x_mem[x_addr];
    wt_rdata <= w_mem[wt_addr];
  end

  assign act_out = (relu && act_in < 0) ? '0 : act_in;

  fc_layer_sequencer #(
    .IP_DATA_WIDTH      (8),
    .NUM_IP             (8),
    .IP_LAYER_NEURONS   (3),
    .DENSE_LAYER_NEURONS(2),
    .FRAC_BITS          (4),
    .ACC_WIDTH          (24),
    .ADDR_WIDTH         (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .x_addr   (x_addr),
    .x_rdata  (x_rdata),
    .wt_addr  (wt_addr),
    .wt_rdata (wt_rdata),
    .act_in   (act_in),
    .act_out  (act_out),
    .out      (out),
    .out_valid(out_valid)
  );

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic load_uniform(input int xv, input int wv);
    for (int i = 0; i < 256; i++) begin
      x_mem[i] = (i < 8) ? W'(xv) : '0;
      w_mem[i] = (i < 32) ? W'(wv) : '0;
    end
  endtask

  // Hand-computed: hid = 28,56,84; dns = 56,84; out pre-activation = -28.
  task automatic load_varied();
    for (int i = 0; i < 256; i++) begin
      x_mem[i] = '0;
      w_mem[i] = '0;
    end
    for (int i = 0; i < 7; i++) x_mem[i] = 8'sd16;
    for (int n = 0; n < 3; n++)
      for (int i = 0; i < 8; i++) w_mem[n*8+i] = W'(4 * (n + 1));
    w_mem[24] = 8'sd16;  w_mem[25] = -8'sd16; w_mem[26] = 8'sd16;
    w_mem[27] = 8'sd0;   w_mem[28] = 8'sd0;   w_mem[29] = 8'sd16;
    w_mem[30] = 8'sd16;  w_mem[31] = -8'sd16;
  endtask

  // Called at a negedge; the next posedge accepts start. Returns at the negedge of the done cycle.
  task automatic do_run(input bit keep, input string tag, input int eh0, input int eh1,
                        input int eh2, input int ed0, input int ed1, input int eop,
                        input int eout);
    int exp_act [6];
    int act_t [6];
    int addr_bad;
    int busy_bad;
    int k;
    int c;
    int ewt;
    exp_act  = '{eh0, eh1, eh2, ed0, ed1, eop};
    act_t    = '{9, 19, 29, 34, 39, 43};
    addr_bad = 0;
    busy_bad = 0;
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!keep) start = 1'b0;
    for (int t = 0; t < 44; t++) begin
      @(negedge clk);
      if (busy !== 1'b1 || done !== 1'b0) busy_bad++;
      ewt = -1;
      if (t < 30) begin
        k = t / 10;
        c = t % 10;
        if (c < 8) begin
          ewt = k * 8 + c;
          if (x_addr !== AW'(c)) addr_bad++;
        end
      end else begin
        if (x_addr !== '0) addr_bad++;
        if (t < 40) begin
          k = (t - 30) / 5;
          c = (t - 30) % 5;
          if (c < 3) ewt = 24 + k * 3 + c;
        end else begin
          c = t - 40;
          if (c < 2) ewt = 30 + c;
        end
      end
      if (ewt >= 0 && wt_addr !== AW'(ewt)) addr_bad++;
      for (int i = 0; i < 6; i++)
        if (t == act_t[i]) check($sformatf("%s_act%0d", tag, i), act_in, exp_act[i]);
      if (t == 0 || t == 43) check({tag, "_ovld_run"}, out_valid, 0);
    end
    check({tag, "_addr_errs"}, addr_bad, 0);
    check({tag, "_busy_errs"}, busy_bad, 0);
    @(negedge clk);
    check({tag, "_done"}, done, 1);
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_ovld"}, out_valid, 1);
    check({tag, "_out"}, out, eout);
  endtask

  task automatic post_hold(input string tag, input int eout);
    @(negedge clk);
    check({tag, "_done_drop"}, done, 0);
    check({tag, "_ovld_hold"}, out_valid, 1);
    check({tag, "_out_hold"}, out, eout);
  endtask

  initial begin
    int done_seen;
    int busy_seen;
    rst   = 1'b1;
    start = 1'b0;
    relu  = 1'b0;
    load_uniform(16, 4);
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_out", out, 0);
    check("rst_ovld", out_valid, 0);
    check("rst_xaddr", x_addr, 0);
    check("rst_waddr", wt_addr, 0);
    check("rst_actin", act_in, 0);
    rst = 1'b0;
    @(negedge clk);

    do_run(1'b0, "unit", 32, 32, 32, 24, 24, 12, 12);
    post_hold("unit", 12);

    load_uniform(127, 127);
    do_run(1'b0, "satp", 127, 127, 127, 127, 127, 127, 127);
    post_hold("satp", 127);

    load_uniform(127, -128);
    do_run(1'b0, "satn", -128, -128, -128, 127, 127, -128, -128);
    post_hold("satn", -128);

    // start held high across a whole run, second run accepted in the done cycle
    load_uniform(16, 4);
    do_run(1'b1, "hold1", 32, 32, 32, 24, 24, 12, 12);
    do_run(1'b0, "hold2", 32, 32, 32, 24, 24, 12, 12);
    post_hold("hold2", 12);

    // reset in the middle of a run
    load_varied();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_out", out, 0);
    check("midrst_ovld", out_valid, 0);
    check("midrst_waddr", wt_addr, 0);
    check("midrst_actin", act_in, 0);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    busy_seen = 0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (done !== 1'b0) done_seen++;
      if (busy !== 1'b0) busy_seen++;
    end
    check("midrst_no_done", done_seen, 0);
    check("midrst_no_busy", busy_seen, 0);

    do_run(1'b0, "vary", 28, 56, 84, 56, 84, -28, -28);
    post_hold("vary", -28);

    relu = 1'b1;
    do_run(1'b0, "relu", 28, 56, 84, 56, 84, -28, 0);
    post_hold("relu", 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fc_layer_sequencer.md
# fc_layer_sequencer

Time-multiplexed controller for the fully connected stack: one shared MAC computes every hidden neuron, every dense neuron and the single output neuron in order. Weights and hidden-layer inputs come from external synchronous memories; intermediate activations live in internal register files. The block replaces the per-neuron parallel instance array when area matters. Activation is an external combinational unit reached through `act_in`/`act_out`.

## Interface
Parameters:
- `IP_DATA_WIDTH`, 8: signed operand/result width (W)
- `NUM_IP`, 8: inputs per hidden neuron (N)
- `IP_LAYER_NEURONS`, 3: hidden neurons (H)
- `DENSE_LAYER_NEURONS`, 2: dense neurons (D)
- `FRAC_BITS`, 4: fixed-point fraction bits of all operands
- `ACC_WIDTH`, 24: accumulator width; must be ≥ 2W+clog2(max(N,H,D))+1
- `ADDR_WIDTH`, 8: weight/input address width; weight depth H·N+D·H+D must fit

Ports:
- `clk` in 1: clock
- `rst` in 1: reset. One clock; reset is asynchronous and active-high.
- `start` in 1: run request, sampled only in IDLE
- `busy` out 1: high in every non-IDLE state
- `done` out 1: one-cycle pulse after `out` is updated
- `x_addr` out ADDR_WIDTH: input-feature read address
- `x_rdata` in W signed: feature data, 1-cycle read latency
- `wt_addr` out ADDR_WIDTH: weight read address
- `wt_rdata` in W signed: weight data, 1-cycle read latency
- `act_in` out W signed: shifted, saturated pre-activation
- `act_out` in W signed: activation result, combinational from `act_in`
- `out` out W signed: final network output
- `out_valid` out 1: `out` holds a completed result

## Operation
- FSM states: IDLE, MAC, ACT. A layer index (HID, DNS, OUT) and a neuron index qualify MAC/ACT.
- IDLE + `start` → MAC, layer HID, neuron 0, accumulator cleared. `start` in other states is ignored.
- MAC for a neuron with K inputs (N for HID, H for DNS, D for OUT) lasts K+1 cycles. In cycle c<K, drive address for input c; in cycles 1..K, accumulate the product of the previous cycle's operands.
- Weight map: HID neuron n input i → n·N+i; DNS neuron k input j → H·N+k·H+j; OUT input k → H·N+D·H+k. `x_addr`=i in HID only, otherwise 0.
- DNS/OUT data operands come from the internal hid[]/dns[] registers, delayed one cycle to align with `wt_rdata`.
- ACT, 1 cycle: `act_in` = sat_W(acc >>> FRAC_BITS), an arithmetic shift that saturates to [−2^(W−1), 2^(W−1)−1]. `act_out` is written to hid[n], dns[k] or `out`.
- ACT → next neuron's MAC (accumulator cleared), next layer when the neuron index wraps, or IDLE after OUT. Leaving OUT sets `out_valid`=1 and pulses `done`.
- Products are full 2W-bit signed values. With the width rule above, the accumulator never overflows.
- `out`/`out_valid` hold until the next accepted `start`. `out_valid` clears on that start edge.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `out`=0, `out_valid`=0, `x_addr`=`wt_addr`=0, `act_in`=0, hid[]/dns[] all 0.
- `rst` mid-run: immediate return to the reset state, no `done`. The run is lost.
- Per-neuron cycles: K+2. Total = H(N+2)+D(H+2)+(D+2) = 44 with defaults.
- `start` sampled at edge e0 → `busy` high from e0. `out` and `out_valid` update at edge e0+44. `done` is high for the cycle after e0+44 and `busy` is low in that cycle.
- `start` asserted during the `done` cycle is accepted, giving back-to-back runs with no dead cycle.
- Memory reads: address at edge t, data consumed at edge t+1. The block never stalls.

## Structure
- Package `fc_pkg`: state enum, layer enum, weight-base offset functions (HID_BASE, DNS_BASE, OUT_BASE as functions of N, H, D), and a `sat_shift` function.
- Sub-module `fc_mac_unit`: signed multiply, accumulate with clear/enable, shift and saturate output. The FSM, address generation and register files stay in `fc_layer_sequencer`.

## Test plan
Bench activation is identity unless stated.
- x=16 (1.0), all weights 4 (0.25) → hid=32, dns=24, `out`=12. `done` pulses in the cycle after edge e0+44.
- x=127, weights 127 → every stage saturates: hid=dns=`out`=127.
- x=127, weights −128 → hid=−128, dns=127, `out`=−128, exercising both saturation rails.
- `start` held high throughout a run → the run is not restarted. A second run begins in the `done` cycle, with `out_valid` low from that edge until 44 cycles later.
- `rst` pulsed at cycle 20 of a run → all outputs return to 0 and no `done` occurs. A fresh `start` then completes with the correct `out`.
- Address check: the `wt_addr` sequence is 0..23 (HID), 24..29 (DNS), 30..31 (OUT), each followed by the idle drain/ACT cycles. `x_addr` cycles 0..7 three times.
